// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and operation latencies.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  // Counter load values: busy spans LAT cycles, the last of which sees cnt==0.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT_INIT = 4'(DIV_LAT - 1);

endpackage

// File: rtl/md_calc.sv
// Combinational arithmetic for mul_div_unit: 64-bit {hi,lo} result from op,
// rs and rt. res_vld_o is low for divide-by-zero (result must be discarded).
module md_calc
  import md_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [63:0] res_o,
  output logic        res_vld_o
);

  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s;

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // with zero remainder instead of hitting a signed-overflow corner.
  always_comb begin
    a_mag = rs_i[31] ? (32'd0 - rs_i) : rs_i;
    b_mag = rt_i[31] ? (32'd0 - rt_i) : rt_i;
    q_mag = (b_mag == '0) ? '0 : (a_mag / b_mag);
    r_mag = (b_mag == '0) ? '0 : (a_mag % b_mag);
    q_s   = (rs_i[31] ^ rt_i[31]) ? (32'd0 - q_mag) : q_mag;
    r_s   = rs_i[31] ? (32'd0 - r_mag) : r_mag;
  end

  // Result select per operation.
  always_comb begin
    res_o     = '0;
    res_vld_o = 1'b1;
    case (op_i)
      OP_MULT:  res_o = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
      OP_MULTU: res_o = {32'd0, rs_i} * {32'd0, rt_i};
      OP_DIV: begin
        res_o     = {r_s, q_s};
        res_vld_o = (rt_i != '0);
      end
      OP_DIVU: begin
        res_o     = (rt_i == '0) ? '0 : {rs_i % rt_i, rs_i / rt_i};
        res_vld_o = (rt_i != '0);
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// at issue and held in pending registers; it lands in HI/LO when the fixed
// latency counter expires.
module mul_div_unit
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;

  md_op_e      op;
  logic [63:0] calc_res;
  logic        calc_vld;

  assign op = md_op_e'(md_op);

  md_calc u_calc (
    .op_i      (op),
    .rs_i      (rs),
    .rt_i      (rt),
    .res_o     (calc_res),
    .res_vld_o (calc_vld)
  );

  // State, counter, HI/LO and pending result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  // Next-state: issue only from IDLE; in-flight ops ignore start and cancel.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_d     = calc_res;
              pend_vld_d = 1'b1;
              cnt_d      = MUL_CNT_INIT;
              state_d    = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              pend_d     = calc_res;
              pend_vld_d = calc_vld;
              cnt_d      = DIV_CNT_INIT;
              state_d    = ST_DIV;
            end
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == '0) begin
          if (pend_vld_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit with a behavioural HI/LO model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [2:0]  md_op;
  logic [31:0] rs, rt;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_hi, exp_lo;

  mul_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .cancel (cancel),
    .rs     (rs),
    .rt     (rt),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  // Architectural result of one op applied to the current {hi,lo}.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] ch,
                                             input logic [31:0] cl);
    int sa, sb;
    longint sp, sq, sr;
    logic [63:0] r;
    sa = a;
    sb = b;
    r = {ch, cl};
    case (op)
      3'd0: begin sp = longint'(sa) * longint'(sb); r = sp; end
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: if (b != 0) begin
        sq = longint'(sa) / longint'(sb);
        sr = longint'(sa) % longint'(sb);
        r = {sr[31:0], sq[31:0]};
      end
      3'd3: if (b != 0) r = {a % b, a / b};
      3'd4: r[63:32] = a;
      3'd5: r[31:0] = a;
      default: ;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op);
    if (op <= 3'd1) return 5;
    if (op <= 3'd3) return 10;
    return 0;
  endfunction

  // Issue one op (called at posedge+1) and check busy span, hold and result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic canc);
    logic [63:0] nxt;
    int lat, n;
    nxt = canc ? {exp_hi, exp_lo} : ref_result(op, a, b, exp_hi, exp_lo);
    lat = canc ? 0 : ref_lat(op);
    start = 1'b1; md_op = op; rs = a; rt = b; cancel = canc;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    rs = $urandom; rt = $urandom;
    n = 0;
    while (busy && n < 20) begin
      checks++;
      if (hi !== exp_hi || lo !== exp_lo)
        $display("FAIL hold op=%0d hi=%h lo=%h expected hi=%h lo=%h", op, hi, lo, exp_hi, exp_lo);
      else passed++;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== lat) $display("FAIL busy_len op=%0d got %0d expected %0d", op, n, lat);
    else passed++;
    exp_hi = nxt[63:32];
    exp_lo = nxt[31:0];
    checks++;
    if (hi !== exp_hi || lo !== exp_lo)
      $display("FAIL result op=%0d a=%h b=%h hi=%h lo=%h expected hi=%h lo=%h",
               op, a, b, hi, lo, exp_hi, exp_lo);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; md_op = 3'd4; cancel = 1'b0; rs = 32'hDEADBEEF; rt = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    exp_hi = '0; exp_lo = '0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL reset busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    else passed++;
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA)
      $display("FAIL mult_vec hi=%h lo=%h expected ffffffff/fffffffa", hi, lo);
    else passed++;
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001)
      $display("FAIL multu_vec hi=%h lo=%h expected fffffffe/00000001", hi, lo);
    else passed++;
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD)
      $display("FAIL div_vec hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
    else passed++;
    run_op(3'd3, 32'd7, 32'd0, 1'b0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h80000000)
      $display("FAIL div_ovf hi=%h lo=%h expected 00000000/80000000", hi, lo);
    else passed++;
    run_op(3'd4, 32'h12345678, 32'd0, 1'b0);
    checks++;
    if (hi !== 32'h12345678) $display("FAIL mthi hi=%h expected 12345678", hi);
    else passed++;
    run_op(3'd5, 32'hCAFEF00D, 32'd0, 1'b1);
    run_op(3'd6, 32'h11111111, 32'd5, 1'b0);
    run_op(3'd7, 32'h22222222, 32'd5, 1'b0);
    run_op(3'd2, 32'd100, 32'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      run_op(op, a, b, ($urandom_range(0, 5) == 0));
    end
  endtask

  // Start/cancel pulses during an in-flight op must not disturb it.
  task automatic test_busy_start_ignored();
    logic [63:0] nxt;
    int n;
    nxt = ref_result(3'd0, 32'h00012345, 32'hFFFF0003, exp_hi, exp_lo);
    start = 1'b1; md_op = 3'd0; rs = 32'h00012345; rt = 32'hFFFF0003;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd2; rs = 32'd1000; rt = 32'd3; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd4; cancel = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 3;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 5) $display("FAIL ignore_len got %0d expected 5", n);
    else passed++;
    exp_hi = nxt[63:32]; exp_lo = nxt[31:0];
    checks++;
    if (hi !== exp_hi || lo !== exp_lo)
      $display("FAIL ignore_result hi=%h lo=%h expected hi=%h lo=%h", hi, lo, exp_hi, exp_lo);
    else passed++;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; md_op = 3'd3; rs = 32'd1000; rt = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL reset_mid busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    else passed++;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL reset_mid_late busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; md_op = '0; rs = '0; rt = '0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_busy_start_ignored();
    test_reset_mid();
    run_op(3'd1, 32'h0000FFFF, 32'h00010001, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The port clk (input, 1 bit) SHALL be the single clock; all state updates on its rising edge.
REQ-002 The port reset (input, 1 bit) SHALL be the reset, synchronous and active-high.
REQ-003 The port start (input, 1 bit) SHALL request an operation; it is qualified by md_op and comes from the E-stage pipeline register.
REQ-004 The port md_op (input, 3 bits) SHALL select the operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-005 The port cancel (input, 1 bit) SHALL suppress the start sampled in the same cycle; it is driven by the exception/flush logic.
REQ-006 The port rs (input, 32 bits) SHALL carry operand A (forwarded RS value).
REQ-007 The port rt (input, 32 bits) SHALL carry operand B (forwarded RT value).
REQ-008 The port busy (output, 1 bit) SHALL be high while a multiply or divide is in flight; the hazard unit uses it to drop the pipeline enable.
REQ-009 The port hi (output, 32 bits) SHALL expose the HI register.
REQ-010 The port lo (output, 32 bits) SHALL expose the LO register.

Function
REQ-011 The unit SHALL implement an FSM with states IDLE, MUL and DIV, plus a 4-bit cycle counter.
REQ-012 In IDLE, an edge with start=1, cancel=0 and md_op in {0..3} SHALL capture the operands, compute the 64-bit result into pending registers, load the counter, and enter MUL (ops 0-1) or DIV (ops 2-3).
REQ-013 busy SHALL equal (state != IDLE) and SHALL be a registered output with no combinational path from start.
REQ-014 MUL SHALL hold busy high for exactly 5 cycles, and DIV for exactly 10 cycles, counted from the start edge.
REQ-015 On the edge that ends the count, the unit SHALL write {hi,lo} from the pending registers, drop busy and return to IDLE; hi/lo SHALL be unchanged before that edge.
REQ-016 MULT SHALL produce the signed 32x32->64 product and MULTU the unsigned product, with hi = bits[63:32] and lo = bits[31:0].
REQ-017 DIV/DIVU SHALL set lo = quotient and hi = remainder; the signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-018 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-019 Division by zero SHALL run the full 10 busy cycles and leave hi/lo unchanged.
REQ-020 MTHI/MTLO SHALL be accepted only in IDLE with start=1 and cancel=0, and SHALL write rs into hi or lo respectively on that edge, with busy staying 0.
REQ-021 start while busy=1 SHALL be ignored; the stall logic guarantees it is not issued, and the unit SHALL not corrupt an in-flight operation.
REQ-022 cancel SHALL have no effect on an operation already in flight, since that operation belongs to an older instruction.
REQ-023 md_op values 6-7 with start=1 SHALL cause no state change.

Reset
REQ-024 When reset=1 on an edge, the unit SHALL set state=IDLE, counter=0, busy=0, hi=0, lo=0 and clear the pending registers.
REQ-025 Reset SHALL take priority over start and cancel.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no hi/lo write.

Structure
REQ-027 A shared package md_pkg SHALL hold the md_op encodings, the FSM state enumeration, and the constants MUL_LAT=5 and DIV_LAT=10.
REQ-028 The unit SHALL be a single module; an optional combinational sub-module md_calc (64-bit result from op, rs and rt) MAY isolate the arithmetic.
REQ-029 The E-stage pipeline register and the hazard unit SHALL remain outside this module.

Verification
REQ-030 MULT: rs=0xFFFFFFFE, rt=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-031 MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE and lo=0x00000001 after 5 busy cycles.
REQ-032 DIV: rs=0xFFFFFFF9 (-7), rt=2 -> busy high for 10 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU 7/0 leaves hi/lo unchanged.
REQ-033 MTHI with rs=0x12345678 -> hi=0x12345678 on the next edge with busy=0; start+MTLO with cancel=1 -> lo unchanged.
REQ-034 Start MULT, pulse start with DIV at busy cycle 2 -> the DIV is ignored and the MULT result is written at cycle 5.
REQ-035 Start DIV, assert reset at busy cycle 4 -> the next cycle shows busy=0, hi=0, lo=0 and no later write occurs.
